// File: rtl/fp_compare_vec.sv
// fp_compare_vec: pipelined IEEE-754 single-precision compare/min/max unit.
// LANES independent 32-bit lanes share one op select; LATENCY register stages
// with a valid tag and a global stall. All compare logic feeds stage 1; the
// remaining stages are pure delay.
// Optional: define FP_COMPARE_VEC_FLAGS_EN to add the per-lane out_invalid
// flag output, pipelined alongside out_q.
module fp_compare_vec #(
  parameter int unsigned LANES   = 1,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  in_valid,
  input  logic [2:0]            in_op,
  input  logic [32*LANES-1:0]   in_a,
  input  logic [32*LANES-1:0]   in_b,
  input  logic                  stall,
  output logic                  out_valid,
  output logic [32*LANES-1:0]   out_q
`ifdef FP_COMPARE_VEC_FLAGS_EN
  ,
  output logic [LANES-1:0]      out_invalid
`endif
);

  localparam int unsigned DW = 32 * LANES;

  localparam logic [2:0] OP_LT  = 3'b000;
  localparam logic [2:0] OP_LE  = 3'b001;
  localparam logic [2:0] OP_EQ  = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] RES_TRUE  = 32'h0000_0001;
  localparam logic [31:0] RES_FALSE = 32'h0000_0000;

  // NaN: exponent all ones with a nonzero mantissa.
  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // +0 or -0.
  function automatic logic f_is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

  // Map sign-magnitude onto an unsigned total order: negatives are inverted
  // so larger magnitudes sort lower, positives get the top bit set. This puts
  // -0 just below +0, which is exactly the MIN/MAX tie-break we want.
  function automatic logic [31:0] f_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  // Per-lane result for the selected op.
  function automatic logic [31:0] f_lane_result(input logic [2:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
    logic        na;
    logic        nb;
    logic        any_nan;
    logic        both_zero;
    logic [31:0] ka;
    logic [31:0] kb;
    logic        lt;
    logic        eq;
    logic [31:0] r;
    na        = f_is_nan(a);
    nb        = f_is_nan(b);
    any_nan   = na | nb;
    both_zero = f_is_zero(a) & f_is_zero(b);
    ka        = f_key(a);
    kb        = f_key(b);
    // Arithmetic compares: signed zeros equal, NaN unordered.
    lt        = !any_nan && !both_zero && (ka < kb);
    eq        = !any_nan && (both_zero || (a == b));
    r         = RES_FALSE;
    case (op)
      OP_LT:   r = lt ? RES_TRUE : RES_FALSE;
      OP_LE:   r = (lt || eq) ? RES_TRUE : RES_FALSE;
      OP_EQ:   r = eq ? RES_TRUE : RES_FALSE;
      OP_MIN: begin
        if (na && nb)      r = CANON_NAN;
        else if (na)       r = b;
        else if (nb)       r = a;
        else if (ka <= kb) r = a;
        else               r = b;
      end
      OP_MAX: begin
        if (na && nb)      r = CANON_NAN;
        else if (na)       r = b;
        else if (nb)       r = a;
        else if (ka >= kb) r = a;
        else               r = b;
      end
      default: r = RES_FALSE;
    endcase
    return r;
  endfunction

`ifdef FP_COMPARE_VEC_FLAGS_EN
  // Signalling NaN: NaN with the quiet bit clear.
  function automatic logic f_is_snan(input logic [31:0] x);
    return f_is_nan(x) && !x[22];
  endfunction

  // Invalid-operation flag: ordered compares trap on any NaN, the rest on sNaN.
  function automatic logic f_lane_invalid(input logic [2:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (op)
      OP_LT, OP_LE:          r = f_is_nan(a) | f_is_nan(b);
      OP_EQ, OP_MIN, OP_MAX: r = f_is_snan(a) | f_is_snan(b);
      default:               r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  logic [DW-1:0] res_c;
  logic          v_pipe [LATENCY];
  logic [DW-1:0] q_pipe [LATENCY];

  // Stage-1 compute: every lane evaluated in parallel from the raw inputs.
  always_comb begin
    res_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      res_c[32*i +: 32] = f_lane_result(in_op, in_a[32*i +: 32], in_b[32*i +: 32]);
    end
  end

  // Valid/data pipeline: reset clears, stall freezes, otherwise shift by one.
  // Stage-1 data only loads on a valid beat so bubbles never pull in junk.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        v_pipe[s] <= 1'b0;
        q_pipe[s] <= '0;
      end
    end else if (!stall) begin
      v_pipe[0] <= in_valid;
      if (in_valid) begin
        q_pipe[0] <= res_c;
      end
      for (int unsigned s = 1; s < LATENCY; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        q_pipe[s] <= q_pipe[s-1];
      end
    end
  end

  assign out_valid = v_pipe[LATENCY-1];
  assign out_q     = q_pipe[LATENCY-1];

`ifdef FP_COMPARE_VEC_FLAGS_EN
  logic [LANES-1:0] inv_c;
  logic [LANES-1:0] inv_pipe [LATENCY];

  // Stage-1 flag compute, one bit per lane.
  always_comb begin
    inv_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inv_c[i] = f_lane_invalid(in_op, in_a[32*i +: 32], in_b[32*i +: 32]);
    end
  end

  // Flag pipeline, stalled and reset in lockstep with the data pipeline.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        inv_pipe[s] <= '0;
      end
    end else if (!stall) begin
      if (in_valid) begin
        inv_pipe[0] <= inv_c;
      end
      for (int unsigned s = 1; s < LATENCY; s++) begin
        inv_pipe[s] <= inv_pipe[s-1];
      end
    end
  end

  assign out_invalid = inv_pipe[LATENCY-1];
`endif

endmodule

// File: tb/tb_fp_compare_vec.sv
// Bench for fp_compare_vec: two instances (LANES=1/LATENCY=2 and
// LANES=4/LATENCY=1) driven in lockstep by a shared control stream.
module tb_fp_compare_vec;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  localparam logic [2:0] LT  = 3'd0;
  localparam logic [2:0] LE  = 3'd1;
  localparam logic [2:0] EQ  = 3'd2;
  localparam logic [2:0] MIN = 3'd3;
  localparam logic [2:0] MAX = 3'd4;

  logic         clk;
  logic         areset;
  logic         in_valid;
  logic         stall;
  logic [2:0]   in_op;
  logic [31:0]  a_a, b_a, q_a;
  logic [127:0] a_b, b_b, q_b;
  logic         ov_a, ov_b;
`ifdef FP_COMPARE_VEC_FLAGS_EN
  logic [0:0]   inv_a;
  logic [3:0]   inv_b;
`endif

  fp_compare_vec #(.LANES(1), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_op(in_op),
    .in_a(a_a), .in_b(b_a), .stall(stall), .out_valid(ov_a), .out_q(q_a)
`ifdef FP_COMPARE_VEC_FLAGS_EN
    , .out_invalid(inv_a)
`endif
  );

  fp_compare_vec #(.LANES(4), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_op(in_op),
    .in_a(a_b), .in_b(b_b), .stall(stall), .out_valid(ov_b), .out_q(q_b)
`ifdef FP_COMPARE_VEC_FLAGS_EN
    , .out_invalid(inv_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] q;
    logic [3:0]   inv;
    int           due;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        inv;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  logic cv_a, cv_b;
  int   adv;
  int   checks;
  int   errors;
  vec_t tab[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Real value of a non-NaN float; infinities map beyond any finite float.
  function automatic real fval(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'hFF) return x[31] ? -1.0e300 : 1.0e300;
    m = x[22:0];
    if (x[30:23] == 8'h00) begin
      e = -149;
    end else begin
      m = m + 8388608.0;
      e = int'(x[30:23]) - 150;
    end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic m_snan(input logic [31:0] x);
    return m_nan(x) && (x[22] == 1'b0);
  endfunction

  function automatic logic [31:0] ref_q(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic na, nb;
    real  va, vb;
    na = m_nan(a);
    nb = m_nan(b);
    va = na ? 0.0 : fval(a);
    vb = nb ? 0.0 : fval(b);
    case (op)
      LT: return 32'(!na && !nb && (va < vb));
      LE: return 32'(!na && !nb && (va <= vb));
      EQ: return 32'(!na && !nb && (va == vb));
      MIN: begin
        if (na && nb) return 32'h7FC0_0000;
        if (na) return b;
        if (nb) return a;
        if (va < vb) return a;
        if (vb < va) return b;
        return a[31] ? a : b;
      end
      MAX: begin
        if (na && nb) return 32'h7FC0_0000;
        if (na) return b;
        if (nb) return a;
        if (va > vb) return a;
        if (vb > va) return b;
        return a[31] ? b : a;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_inv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == LT || op == LE) return m_nan(a) || m_nan(b);
    if (op == EQ || op == MIN || op == MAX) return m_snan(a) || m_snan(b);
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return {r[31], 8'hFF, 1'b1, r[21:0]};
      5: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      6: return {r[31], 8'h00, r[22:0]};
      7: return 32'h3F80_0000;
      8: return 32'hBF80_0000;
      9: return {r[31], 8'h01, r[22:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    case ($urandom_range(0, 9))
      0, 1, 2: return a;
      3:       return a ^ 32'h8000_0000;
      4:       return a + 32'd1;
      default: return rand_f();
    endcase
  endfunction

  // One clock: drive inputs, advance the reference, compare both instances.
  task automatic beat(input logic v, input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                      input logic st, input logic rst, input logic have_exp,
                      input logic [127:0] eq4, input logic [3:0] einv4);
    exp_t e;
    in_valid = v;
    in_op    = op;
    stall    = st;
    areset   = rst;
    a_a      = a[31:0];
    b_a      = b[31:0];
    a_b      = a;
    b_b      = b;
    @(posedge clk);
    #1;
    if (rst) begin
      qa.delete();
      qb.delete();
      cv_a = 1'b0;
      cv_b = 1'b0;
      chk("reset_q_a", 128'(q_a), 128'h0);
      chk("reset_q_b", q_b, 128'h0);
`ifdef FP_COMPARE_VEC_FLAGS_EN
      chk("reset_inv_b", 128'(inv_b), 128'h0);
`endif
    end else if (!st) begin
      adv++;
      if (v) begin
        if (have_exp) begin
          e.q   = eq4;
          e.inv = einv4;
        end else begin
          for (int l = 0; l < 4; l++) begin
            e.q[32*l +: 32] = ref_q(op, a[32*l +: 32], b[32*l +: 32]);
            e.inv[l]        = ref_inv(op, a[32*l +: 32], b[32*l +: 32]);
          end
        end
        e.due = adv + LAT_A - 1;
        qa.push_back(e);
        e.due = adv + LAT_B - 1;
        qb.push_back(e);
      end
      cv_a = 1'b0;
      if (qa.size() > 0 && qa[0].due == adv) begin
        cur_a = qa.pop_front();
        cv_a  = 1'b1;
      end
      cv_b = 1'b0;
      if (qb.size() > 0 && qb[0].due == adv) begin
        cur_b = qb.pop_front();
        cv_b  = 1'b1;
      end
    end
    chk("valid_a", 128'(ov_a), 128'(cv_a));
    chk("valid_b", 128'(ov_b), 128'(cv_b));
    chk("known_q_a", 128'($isunknown(q_a)), 128'h0);
    chk("known_q_b", 128'($isunknown(q_b)), 128'h0);
    if (cv_a) chk("q_a", 128'(q_a), 128'(cur_a.q[31:0]));
    if (cv_b) chk("q_b", q_b, cur_b.q);
`ifdef FP_COMPARE_VEC_FLAGS_EN
    if (cv_a) chk("inv_a", 128'(inv_a), 128'(cur_a.inv[0]));
    if (cv_b) chk("inv_b", 128'(inv_b), 128'(cur_b.inv));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, LT, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [127:0] ra, rb;
    logic [2:0]   rop;
    checks = 0;
    errors = 0;
    adv    = 0;
    cv_a   = 1'b0;
    cv_b   = 1'b0;

    tab[0]  = '{LT,     32'h3F800000, 32'h40000000, 32'h1,        1'b0};
    tab[1]  = '{LE,     32'h3F800000, 32'h3F800000, 32'h1,        1'b0};
    tab[2]  = '{LE,     32'h80000000, 32'h00000000, 32'h1,        1'b0};
    tab[3]  = '{LE,     32'h7FC00000, 32'h3F800000, 32'h0,        1'b1};
    tab[4]  = '{EQ,     32'h80000000, 32'h00000000, 32'h1,        1'b0};
    tab[5]  = '{LT,     32'h80000000, 32'h00000000, 32'h0,        1'b0};
    tab[6]  = '{MIN,    32'h00000000, 32'h80000000, 32'h80000000, 1'b0};
    tab[7]  = '{MAX,    32'h7FA00000, 32'hBF800000, 32'hBF800000, 1'b1};
    tab[8]  = '{MIN,    32'h7FC00000, 32'h7F800001, 32'h7FC00000, 1'b1};
    tab[9]  = '{MAX,    32'h00000000, 32'h80000000, 32'h00000000, 1'b0};
    tab[10] = '{LT,     32'hC0000000, 32'hBF800000, 32'h1,        1'b0};
    tab[11] = '{EQ,     32'h7FC00000, 32'h7FC00000, 32'h0,        1'b0};
    tab[12] = '{LT,     32'h00000001, 32'h00000002, 32'h1,        1'b0};
    tab[13] = '{3'b111, 32'h3F800000, 32'h3F800000, 32'h0,        1'b0};

    beat(1'b0, LT, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    beat(1'b0, LT, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Single beat, then bubbles.
    beat(1'b1, LT, {4{32'h3F800000}}, {4{32'h40000000}}, 1'b0, 1'b0, 1'b1, {4{32'h1}}, 4'h0);
    idle(3);

    // Back-to-back table beats.
    foreach (tab[i]) begin
      beat(1'b1, tab[i].op, {4{tab[i].a}}, {4{tab[i].b}}, 1'b0, 1'b0, 1'b1,
           {4{tab[i].q}}, {4{tab[i].inv}});
    end
    idle(3);

    // Stall for three edges right behind an accepted beat; stalled inputs ignored.
    beat(1'b1, LT, {4{32'hC0000000}}, {4{32'hBF800000}}, 1'b0, 1'b0, 1'b1, {4{32'h1}}, 4'h0);
    for (int i = 0; i < 3; i++)
      beat(1'b1, EQ, {4{32'h3F800000}}, {4{32'h3F800000}}, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);

    // Reset while stalled with two beats in flight.
    beat(1'b1, LE, {4{32'h3F800000}}, {4{32'h3F800000}}, 1'b0, 1'b0, 1'b1, {4{32'h1}}, 4'h0);
    beat(1'b1, LT, {4{32'h3F800000}}, {4{32'h40000000}}, 1'b0, 1'b0, 1'b1, {4{32'h1}}, 4'h0);
    beat(1'b1, LT, '0, '0, 1'b1, 1'b1, 1'b0, '0, '0);
    idle(4);

    // Per-lane independence and reserved op.
    beat(1'b1, MAX, {32'h40400000, 32'h40000000, 32'h3F800000, 32'h00000000},
                    {32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000}, 1'b0, 1'b0, 1'b1,
                    {32'h40400000, 32'h40000000, 32'h40000000, 32'h40400000}, 4'h0);
    beat(1'b1, 3'b111, {4{32'h3F800000}}, {4{32'h40000000}}, 1'b0, 1'b0, 1'b1, '0, 4'h0);
    idle(3);

    // Randomized traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      for (int l = 0; l < 4; l++) begin
        ra[32*l +: 32] = rand_f();
        rb[32*l +: 32] = rand_b(ra[32*l +: 32]);
      end
      if ($urandom_range(0, 7) == 0) rop = 3'($urandom_range(5, 7));
      else                           rop = 3'($urandom_range(0, 4));
      beat($urandom_range(0, 9) < 7, rop, ra, rb, $urandom_range(0, 9) < 2,
           $urandom_range(0, 199) == 0, 1'b0, '0, '0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
